// File: rtl/uart_rx_core.sv
// uart_rx_core
//   Serial-to-parallel UART receiver for the uart_rxd pin. Deframes 8N1 frames
//   (8E1 when UART_RX_PARITY_EN is defined), majority-votes each bit around
//   mid-period and pushes {framing/parity error, byte} into a small
//   first-word-fall-through FIFO.
//
//   Parameters: BAUD_DIV   clock cycles per bit (16..65535)
//               FIFO_DEPTH receive FIFO entries (power of two, 2..16)
//   Macro:      UART_RX_PARITY_EN  adds an even-parity bit after the data bits
//
//   Ports: clk_in    system clock (rising edge)
//          sys_rstn  asynchronous active-low reset
//          uart_rxd  serial line, idle high, asynchronous to clk_in
//          rd_en     pop FIFO head (ignored when empty)
//          clr_err   clear sticky overrun
//          rd_data   FIFO head byte
//          rd_ferr   framing/parity error flag of FIFO head
//          rd_valid  FIFO not empty
//          overrun   sticky, a byte was dropped on a full FIFO
//          busy      receiver FSM not idle
//
//   state     | meaning
//   ----------+-----------------------------------------------------
//   IDLE      | line idle, waiting for a falling edge
//   START     | validating the start bit
//   DATA      | shifting in 8 data bits, LSB first
//   PARITY    | checking the even-parity bit (parity build only)
//   STOP      | sampling the stop bit, pushes the byte at resolution
//   WAIT_IDLE | stop bit was low (break), waiting for the line to go high

module uart_rx_core #(
    parameter int BAUD_DIV   = 325,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk_in,
    input  logic       sys_rstn,
    input  logic       uart_rxd,
    input  logic       rd_en,
    input  logic       clr_err,
    output logic [7:0] rd_data,
    output logic       rd_ferr,
    output logic       rd_valid,
    output logic       overrun,
    output logic       busy
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [15:0] CNT_MAX = 16'(BAUD_DIV - 1);
    localparam logic [15:0] MID_M1  = 16'(BAUD_DIV / 2 - 1);
    localparam logic [15:0] MID     = 16'(BAUD_DIV / 2);
    localparam logic [15:0] MID_P1  = 16'(BAUD_DIV / 2 + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_WAIT_IDLE
    } state_t;

    state_t      r_state;
    logic [1:0]  r_sync;
    logic        r_rxd_prev;
    logic [15:0] r_cnt;
    logic        r_s0;
    logic        r_s1;
    logic [7:0]  r_shreg;
    logic [2:0]  r_bitidx;
    logic        r_perr;

    logic [AW:0] r_wptr;
    logic [AW:0] r_rptr;
    logic [8:0]  r_mem [FIFO_DEPTH];

    logic        w_rxd_s;
    logic        w_fall;
    logic        w_wrap;
    logic        w_at_res;
    logic        w_bit;
    logic        w_push;
    logic [8:0]  w_push_data;
    logic        w_empty;
    logic        w_full;
    logic        w_pop;
    logic        w_wr;

    assign w_rxd_s  = r_sync[1];
    assign w_fall   = r_rxd_prev & ~w_rxd_s;
    assign w_wrap   = (r_cnt == CNT_MAX);
    assign w_at_res = (r_cnt == MID_P1);
    // Third vote is the live synchronised line at mid+1.
    assign w_bit    = (r_s0 & r_s1) | (r_s0 & w_rxd_s) | (r_s1 & w_rxd_s);

    assign w_push      = (r_state == S_STOP) && w_at_res;
    assign w_push_data = {r_perr | ~w_bit, r_shreg};

    always_ff @(posedge clk_in or negedge sys_rstn) begin
        if (!sys_rstn) begin
            r_sync     <= 2'b11;
            r_rxd_prev <= 1'b1;
        end else begin
            r_sync     <= {r_sync[0], uart_rxd};
            r_rxd_prev <= w_rxd_s;
        end
    end

    always_ff @(posedge clk_in or negedge sys_rstn) begin
        if (!sys_rstn) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_s0     <= 1'b1;
            r_s1     <= 1'b1;
            r_shreg  <= '0;
            r_bitidx <= '0;
            r_perr   <= 1'b0;
        end else begin
            if (r_state == S_IDLE || w_wrap)
                r_cnt <= '0;
            else
                r_cnt <= r_cnt + 16'd1;

            if (r_cnt == MID_M1) r_s0 <= w_rxd_s;
            if (r_cnt == MID)    r_s1 <= w_rxd_s;

            case (r_state)
                S_IDLE: begin
                    r_perr   <= 1'b0;
                    r_bitidx <= '0;
                    if (w_fall) r_state <= S_START;
                end
                S_START: begin
                    if (w_at_res && w_bit)
                        r_state <= S_IDLE;
                    else if (w_wrap)
                        r_state <= S_DATA;
                end
                S_DATA: begin
                    if (w_at_res) r_shreg <= {w_bit, r_shreg[7:1]};
                    if (w_wrap) begin
                        r_bitidx <= r_bitidx + 3'd1;
                        if (r_bitidx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            r_state <= S_PARITY;
`else
                            r_state <= S_STOP;
`endif
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    // Even parity: data bits plus parity bit have an even count of ones.
                    if (w_at_res) r_perr <= w_bit ^ (^r_shreg);
                    if (w_wrap) r_state <= S_STOP;
                end
`endif
                S_STOP: begin
                    // Leave at resolution so a back-to-back start edge is not missed.
                    if (w_at_res) r_state <= w_bit ? S_IDLE : S_WAIT_IDLE;
                end
                S_WAIT_IDLE: begin
                    if (w_rxd_s) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy = (r_state != S_IDLE);

    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_pop   = rd_en & ~w_empty;
    // A pop in the same cycle frees the head slot, so a full FIFO can still accept.
    assign w_wr    = w_push & (~w_full | w_pop);

    always_ff @(posedge clk_in or negedge sys_rstn) begin
        if (!sys_rstn) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            overrun <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
        end else begin
            if (w_wr) begin
                r_mem[r_wptr[AW-1:0]] <= w_push_data;
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) r_rptr <= r_rptr + 1'b1;
            if (w_push && w_full && !w_pop)
                overrun <= 1'b1;
            else if (clr_err)
                overrun <= 1'b0;
        end
    end

    assign rd_data  = r_mem[r_rptr[AW-1:0]][7:0];
    assign rd_ferr  = r_mem[r_rptr[AW-1:0]][8];
    assign rd_valid = ~w_empty;

endmodule
